// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 widths, round constants and GF(2^8) helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int c_BLOCK_W = 128;
    localparam int c_WORD_W  = 32;
    localparam int c_ROUNDS  = 10;

    // Round constants for rounds 1..10, round 1 in the top byte
    localparam logic [79:0] c_RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [c_WORD_W-1:0] sub_word(input logic [c_WORD_W-1:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    function automatic logic [c_WORD_W-1:0] mix_column(input logic [c_WORD_W-1:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : AES forward S-box, GF(2^8) inversion followed by affine map.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_byte(i_byte);

endmodule
`default_nettype wire

// File: rtl/aes128_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_pipe
//  Description : Fully pipelined AES-128 encryptor, one block per clock,
//                with the key schedule carried alongside each block.
//  Revision    : 1.0  initial release
// ============================================================================
module aes128_pipe
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_BLOCK_W-1:0] state,
    input  logic [c_BLOCK_W-1:0] key,
    output logic [c_BLOCK_W-1:0] out
);

    logic [c_BLOCK_W-1:0] r_data [0:c_ROUNDS];
    logic [c_BLOCK_W-1:0] r_key  [0:c_ROUNDS-1];
    logic [c_ROUNDS:0]    r_valid;

    logic [c_BLOCK_W-1:0] w_round [1:c_ROUNDS];
    logic [c_BLOCK_W-1:0] w_rkey  [1:c_ROUNDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i <= c_ROUNDS; i++) r_data[i] <= '0;
            for (int i = 0; i < c_ROUNDS; i++)  r_key[i]  <= '0;
        end else begin
            r_valid   <= {r_valid[c_ROUNDS-1:0], 1'b1};
            r_data[0] <= state ^ key;
            r_key[0]  <= key;
            for (int i = 1; i <= c_ROUNDS; i++) r_data[i] <= w_round[i];
            for (int i = 1; i < c_ROUNDS; i++)  r_key[i]  <= w_rkey[i];
        end
    end

    // Round gi consumes stage gi-1 registers and produces stage gi contents
    for (genvar gi = 1; gi <= c_ROUNDS; gi++) begin : g_round
        logic [7:0]           w_sb_out [0:15];
        logic [7:0]           w_ks_out [0:3];
        logic [c_BLOCK_W-1:0] w_shifted;
        logic [c_BLOCK_W-1:0] w_mixed;
        logic [c_WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
        logic [c_WORD_W-1:0]  w_rot, w_tmp;
        logic [c_WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;

        for (genvar gb = 0; gb < 16; gb++) begin : g_sbox
            localparam int c_SRC = 4 * (((gb / 4) + (gb % 4)) % 4) + (gb % 4);
            aes_sbox u_sbox (
                .i_byte (r_data[gi-1][127-8*gb -: 8]),
                .o_byte (w_sb_out[gb])
            );
            assign w_shifted[127-8*gb -: 8] = w_sb_out[c_SRC];
        end

        if (gi < c_ROUNDS) begin : g_mix
            for (genvar gc = 0; gc < 4; gc++) begin : g_col
                assign w_mixed[127-32*gc -: 32] = mix_column(w_shifted[127-32*gc -: 32]);
            end
        end else begin : g_nomix
            assign w_mixed = w_shifted;
        end

        assign w_w0  = r_key[gi-1][127:96];
        assign w_w1  = r_key[gi-1][95:64];
        assign w_w2  = r_key[gi-1][63:32];
        assign w_w3  = r_key[gi-1][31:0];
        assign w_rot = {w_w3[23:0], w_w3[31:24]};

        for (genvar gk = 0; gk < 4; gk++) begin : g_ksbox
            aes_sbox u_ksbox (
                .i_byte (w_rot[31-8*gk -: 8]),
                .o_byte (w_ks_out[gk])
            );
        end

        assign w_tmp = {w_ks_out[0], w_ks_out[1], w_ks_out[2], w_ks_out[3]}
                     ^ {c_RCON[79-8*(gi-1) -: 8], 24'h000000};
        assign w_n0  = w_w0 ^ w_tmp;
        assign w_n1  = w_w1 ^ w_n0;
        assign w_n2  = w_w2 ^ w_n1;
        assign w_n3  = w_w3 ^ w_n2;

        assign w_rkey[gi]  = {w_n0, w_n1, w_n2, w_n3};
        assign w_round[gi] = w_mixed ^ w_rkey[gi];
    end

    assign out = r_valid[c_ROUNDS] ? r_data[c_ROUNDS] : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes128_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_pipe
//  Description : Self-checking bench for aes128_pipe against a byte-level
//                AES-128 reference model and FIPS-197 known answers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_pipe;

    localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_K0 = 128'h0;
    localparam logic [127:0] c_P0 = 128'h0;
    localparam logic [127:0] c_C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] st;
    logic [127:0] ky;
    logic [127:0] dout;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] hist [$];
    int           run = 0;
    logic [127:0] exp_out = 128'h0;

    always #5 clk = ~clk;

    aes128_pipe dut (
        .clk   (clk),
        .rst   (rst),
        .state (st),
        .key   (ky),
        .out   (dout)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic       carry;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            carry = a[7];
            a     = a << 1;
            if (carry) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    // S-box by exhaustive inverse search plus the bitwise affine rule
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ cst[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0 ] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++)
                        t[4*c+row] = gmul(s[4*c+row], 8'h02) ^ gmul(s[4*c+(row+1)%4], 8'h03)
                                   ^ s[4*c+(row+2)%4] ^ s[4*c+(row+3)%4];
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = s[4*c+row] ^ w[4*r+c][31-8*row -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // One clock: drive inputs, then update the model's view of out
    task automatic cycle(input logic r, input logic [127:0] s, input logic [127:0] k);
        rst = r;
        st  = s;
        ky  = k;
        @(posedge clk);
        run = r ? 0 : run + 1;
        hist.push_back(r ? 128'h0 : model_enc(s, k));
        if (hist.size() > 11) void'(hist.pop_front());
        #1;
        exp_out = (run >= 11) ? hist[0] : 128'h0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rnd128(), rnd128());
            n_vec++;
            if (dout !== 128'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: out=%h expected=%h", i, dout, 128'h0);
            end
        end
    endtask

    task automatic test_latency();
        logic [127:0] e;
        for (int i = 1; i <= 11; i++) begin
            if (i == 1) cycle(1'b0, c_P0, c_K0);
            else        cycle(1'b0, rnd128(), rnd128());
            e = (i <= 10) ? 128'h0 : c_C0;
            n_vec++;
            if (dout !== e) begin
                n_err++;
                $display("FAIL latency[%0d]: out=%h expected=%h", i, dout, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        for (int j = 1; j <= 13; j++) begin
            case (j)
                1:       cycle(1'b0, c_P1, c_K1);
                2:       cycle(1'b0, c_P2, c_K2);
                3:       cycle(1'b0, c_P0, c_K0);
                default: cycle(1'b0, rnd128(), rnd128());
            endcase
            case (j)
                11:      e = c_C1;
                12:      e = c_C2;
                13:      e = c_C0;
                default: e = exp_out;
            endcase
            n_vec++;
            if (dout !== e) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: out=%h expected=%h", j, dout, e);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [127:0] e;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, c_P1, c_K1);
            n_vec++;
            if (dout !== exp_out) begin
                n_err++;
                $display("FAIL pre_reset[%0d]: out=%h expected=%h", i, dout, exp_out);
            end
        end
        cycle(1'b1, c_P1, c_K1);
        n_vec++;
        if (dout !== 128'h0) begin
            n_err++;
            $display("FAIL reset_edge: out=%h expected=%h", dout, 128'h0);
        end
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, c_P1, c_K1);
            e = (k <= 10) ? 128'h0 : c_C1;
            n_vec++;
            if (dout !== e) begin
                n_err++;
                $display("FAIL post_reset[%0d]: out=%h expected=%h", k, dout, e);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b0, rnd128(), rnd128());
            n_vec++;
            if (dout !== exp_out) begin
                n_err++;
                if (n_err < 20)
                    $display("FAIL random[%0d]: out=%h expected=%h", i, dout, exp_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        st  = 128'h0;
        ky  = 128'h0;
        build_sbox();
        test_reset();
        test_latency();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
